crack_sched: RTL and testbench
==============================

CRACK_SCHED -- requirements
Module: crack_sched

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, meaning the number of ARC4 crack cores scheduled (range 1..8).
REQ-002 SHALL have parameter LAST_KEY, default 24'hFFFFFF, meaning the highest key candidate dispatched.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1, meaning the start request, sampled only while rdy=1.
REQ-006 SHALL have port rdy, output, 1, meaning the scheduler is idle and will accept en.
REQ-007 SHALL have port key_valid, output, 1, meaning the last search found a key.
REQ-008 SHALL have port key, output, 24, meaning the found key, valid while key_valid=1.
REQ-009 SHALL have port core_en, output, NUM_CORES, meaning a one-hot dispatch pulse to the selected core.
REQ-010 SHALL have port core_key, output, 24, meaning the shared candidate bus, valid in the cycle any core_en bit is high.
REQ-011 SHALL have port core_done, input, NUM_CORES, meaning a per-core 1-cycle pulse that the assigned key was tested.
REQ-012 SHALL have port core_ok, input, NUM_CORES, meaning the per-core pass flag, qualified by core_done.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN and DONE; rdy=1 only in IDLE and DONE.
REQ-014 SHALL, on en=1 in IDLE or DONE, clear key_valid, key, next_key (24-bit) and all inflight bits, then enter RUN next cycle.
REQ-015 SHALL, in RUN, dispatch at most one key per cycle to a core whose inflight bit is 0, chosen round-robin starting after the last-granted index.
REQ-016 SHALL, on dispatch, drive core_en one-hot with core_key=next_key, set that core's inflight bit, store next_key in that core's assigned-key register, and increment next_key.
REQ-017 SHALL clear a core's inflight bit in the cycle after its core_done pulse; that core is eligible for dispatch no earlier than that next cycle.
REQ-018 SHALL, on core_done[i] && core_ok[i] in RUN, latch key from core i's assigned-key register, set key_valid=1, stop dispatching and enter DRAIN.
REQ-019 SHALL, when several cores report ok in one cycle, select the lowest index; later ok results are ignored.
REQ-020 SHALL, after dispatching LAST_KEY, stop dispatching without wrapping next_key and enter DRAIN.
REQ-021 SHALL, when a dispatch and a terminating ok occur in the same cycle, suppress the dispatch (core_en=0).
REQ-022 SHALL leave DRAIN for DONE in the cycle after all inflight bits are 0; DONE holds key/key_valid until the next accepted en.
REQ-023 SHALL ignore core_done on cores with inflight=0 and ignore en outside IDLE/DONE.

Reset
REQ-024 SHALL, while rst_n=0, force state=IDLE, rdy=1, key_valid=0, key=0, core_en=0, core_key=0, next_key=0, inflight=0 and the round-robin pointer to core 0, regardless of operation in progress.
REQ-025 SHALL have no outstanding dispatch after reset; in-flight core results arriving after reset are dropped under REQ-023.

Structure
REQ-026 SHALL take KEY_W=24 and the state enum from shared package arc4_pkg.
REQ-027 SHALL implement grant selection in one sub-module rr_arbiter (request=~inflight, one-hot grant, pointer advance on accept).

Verification
REQ-028 Bench SHALL cover: reset, en pulse, 2 cores answering ok=0 after 5 cycles -> keys 0,1,2,... alternate cores 0/1, no key issued twice or skipped.
REQ-029 Bench SHALL cover: core 1 reports ok on key 24'h000007 -> key=24'h000007, key_valid=1, no further core_en, rdy=1 after core 0 drains.
REQ-030 Bench SHALL cover: LAST_KEY=24'h00000F, all ok=0 -> exactly 16 dispatches, DONE with key_valid=0, next_key not wrapped.
REQ-031 Bench SHALL cover: both cores ok in the same cycle (keys 4 and 5) -> key=core 0's key 4, and no dispatch that cycle.
REQ-032 Bench SHALL cover: rst_n low mid-RUN -> all outputs at reset values immediately; subsequent en restarts from key 0.
REQ-033 Bench SHALL cover: en pulsed in RUN -> ignored; en in DONE -> key_valid cleared and a new search starts from key 0.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 key-search scheduler.
//   KEY_W          - width of a key candidate
//   sched_state_t  - scheduler FSM state encoding
//   next_candidate - key advance that holds at the last key instead of wrapping
package arc4_pkg;

    localparam int KEY_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    function automatic logic [KEY_W-1:0] next_candidate(
        input logic [KEY_W-1:0] cur,
        input logic [KEY_W-1:0] last
    );
        return (cur == last) ? cur : cur + KEY_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter selecting one free crack core per cycle.
//   clk, rst_n - clock, async active-low reset (pointer returns to index 0)
//   req        - per-core request (core is free)
//   accept     - grant was used this cycle; advance pointer past the winner
//   grant      - one-hot grant, zero when no request is pending
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    // ptr is the highest-priority index, i.e. one past the last winner.
    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;

    // Two passes: indices at/after ptr first, then the wrapped-around ones.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                grant[j] = 1'b1;
                gidx     = PW'(j);
                found    = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j < int'(ptr))) begin
                grant[j] = 1'b1;
                gidx     = PW'(j);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && found) begin
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
        end
    end

endmodule

// File: rtl/crack_sched.sv
// Dispatches ARC4 key candidates to NUM_CORES crack cores and collects the
// first passing key.
//   clk, rst_n          - clock, async active-low reset
//   en / rdy            - start request, accepted only while rdy=1
//   key_valid / key     - result of the last search
//   core_en / core_key  - one-hot dispatch pulse and shared candidate bus
//   core_done / core_ok - per-core completion pulse and pass flag
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, waiting for en
// ST_RUN   | dispatching candidates to free cores
// ST_DRAIN | no more dispatches, waiting for in-flight cores to finish
// ST_DONE  | result held, waiting for en to start a new search
module crack_sched
    import arc4_pkg::*;
#(
    parameter int               NUM_CORES = 2,
    parameter logic [KEY_W-1:0] LAST_KEY  = 24'hFFFFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    output logic                 rdy,
    output logic                 key_valid,
    output logic [KEY_W-1:0]     key,
    output logic [NUM_CORES-1:0] core_en,
    output logic [KEY_W-1:0]     core_key,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic [NUM_CORES-1:0] core_ok
);

    sched_state_t          state;
    logic [KEY_W-1:0]      next_key;
    logic [NUM_CORES-1:0]  inflight;
    logic [NUM_CORES-1:0]  grant;
    logic [NUM_CORES-1:0]  done_hit;
    logic [NUM_CORES-1:0]  ok_hit;
    logic [KEY_W-1:0]      assigned_key [NUM_CORES];
    logic [KEY_W-1:0]      ok_key;
    logic                  start;
    logic                  term;
    logic                  dispatch;

    assign rdy      = (state == ST_IDLE) || (state == ST_DONE);
    assign start    = rdy && en;
    // Completions from cores we never dispatched to (e.g. pre-reset work) are dropped.
    assign done_hit = core_done & inflight;
    assign ok_hit   = done_hit & core_ok;
    assign term     = (state == ST_RUN) && (|ok_hit);
    // A terminating pass result wins over a dispatch in the same cycle.
    assign dispatch = (state == ST_RUN) && !term && (|grant);
    assign core_en  = dispatch ? grant : '0;
    assign core_key = dispatch ? next_key : '0;

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (~inflight),
        .accept (dispatch),
        .grant  (grant)
    );

    // Descending scan so the lowest passing index is the one kept.
    always_comb begin
        ok_key = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (ok_hit[i]) ok_key = assigned_key[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            key_valid <= 1'b0;
            key       <= '0;
            next_key  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (en) begin
                        state     <= ST_RUN;
                        key_valid <= 1'b0;
                        key       <= '0;
                        next_key  <= '0;
                    end
                end
                ST_RUN: begin
                    if (term) begin
                        key       <= ok_key;
                        key_valid <= 1'b1;
                        state     <= ST_DRAIN;
                    end else if (dispatch) begin
                        if (next_key == LAST_KEY) state <= ST_DRAIN;
                        next_key <= next_candidate(next_key, LAST_KEY);
                    end
                end
                ST_DRAIN: begin
                    if (inflight == '0) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A core's busy bit falls the cycle after its done pulse, so it is
    // re-eligible for dispatch from that cycle on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (start) begin
            inflight <= '0;
        end else begin
            inflight <= (inflight & ~done_hit) | core_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CORES; i++) assigned_key[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (core_en[i]) assigned_key[i] <= next_key;
            end
        end
    end

endmodule

// File: tb/tb_crack_sched.sv
// Scoreboard bench for crack_sched with two behavioural crack cores.
module tb_crack_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        rdy;
    logic        key_valid;
    logic [23:0] key;
    logic [1:0]  core_en;
    logic [23:0] core_key;
    logic [1:0]  core_done = 2'b00;
    logic [1:0]  core_ok = 2'b00;

    crack_sched #(.NUM_CORES(2), .LAST_KEY(24'h00000F)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .key_valid (key_valid),
        .key       (key),
        .core_en   (core_en),
        .core_key  (core_key),
        .core_done (core_done),
        .core_ok   (core_ok)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  en;
        logic [23:0] key;
    } disp_t;

    typedef struct packed {
        logic        kv;
        logic [23:0] key;
    } res_t;

    disp_t exp_q[$];
    res_t  res_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // core model knobs
    logic        ok_on   = 1'b0;
    logic [23:0] ok_a    = 24'h0;
    logic [23:0] ok_b    = 24'h0;
    logic        slow_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic is_ok(input logic [23:0] k);
        return ok_on && ((k == ok_a) || (k == ok_b));
    endfunction

    // Expected dispatches for a fresh search with the pointer at core 0.
    task automatic push_run(input int n);
        disp_t d;
        for (int k = 0; k < n; k++) begin
            d.en  = (k % 2 == 0) ? 2'b01 : 2'b10;
            d.key = 24'(k);
            exp_q.push_back(d);
        end
    endtask

    task automatic push_res(input logic kv, input logic [23:0] k);
        res_t r;
        r.kv  = kv;
        r.key = k;
        res_q.push_back(r);
    endtask

    task automatic do_en();
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
    endtask

    task automatic wait_rdy(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: rdy still %0b after 200 cycles, expected 1", nm, rdy);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy"},       32'(rdy),       32'd1);
        chk({tag, "_key_valid"}, 32'(key_valid), 32'd0);
        chk({tag, "_key"},       32'(key),       32'd0);
        chk({tag, "_core_en"},   32'(core_en),   32'd0);
        chk({tag, "_core_key"},  32'(core_key),  32'd0);
    endtask

    // Behavioural cores: latency 5 cycles (6 for key 4 when slow_on), inputs
    // driven just after the rising edge, dispatches sampled on the falling edge.
    int          cnt [2];
    logic [23:0] ckey [2];
    initial begin
        cnt[0] = 0; cnt[1] = 0;
        ckey[0] = '0; ckey[1] = '0;
        forever begin
            @(posedge clk); #1;
            core_done = 2'b00;
            core_ok   = 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        core_done[i] = 1'b1;
                        core_ok[i]   = is_ok(ckey[i]);
                    end
                end
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (core_en[i]) begin
                    ckey[i] = core_key;
                    cnt[i]  = (slow_on && core_key == 24'd4) ? 6 : 5;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every dispatch and on every rdy rise.
    logic prev_rdy = 1'b1;
    initial begin
        disp_t d;
        res_t  r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rdy = 1'b1;
            end else begin
                if (core_en != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_dispatch", {6'd0, core_en, core_key}, 32'd0);
                    end else begin
                        d = exp_q.pop_front();
                        chk("dispatch_core_en", 32'(core_en), 32'(d.en));
                        chk("dispatch_core_key", 32'(core_key), 32'(d.key));
                    end
                end
                if (rdy && !prev_rdy) begin
                    if (res_q.size() == 0) begin
                        chk("unexpected_result", {7'd0, key_valid, key}, 32'hFFFF_FFFF);
                    end else begin
                        r = res_q.pop_front();
                        chk("result_key_valid", 32'(key_valid), 32'(r.kv));
                        chk("result_key", 32'(key), 32'(r.key));
                    end
                end
                prev_rdy = rdy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        // reset values
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // full sweep, no passes: 16 alternating dispatches, en in RUN ignored
        push_run(16);
        push_res(1'b0, 24'h0);
        do_en();
        chk("run_rdy_low", 32'(rdy), 32'd0);
        repeat (20) @(posedge clk);
        #1 en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        wait_rdy("sweep_done");
        repeat (5) @(negedge clk);
        chk("sweep_hold_rdy", 32'(rdy), 32'd1);

        // core 1 passes key 7; key 8 dispatch suppressed in the same cycle
        ok_on = 1'b1; ok_a = 24'h7; ok_b = 24'hFFFFFF;
        push_run(8);
        push_res(1'b1, 24'h7);
        do_en();
        wait_rdy("pass7_done");
        repeat (5) @(negedge clk);
        chk("pass7_hold_key", 32'(key), 32'h7);

        // en in DONE clears result; keys 4 and 5 pass together -> core 0 wins
        ok_a = 24'h4; ok_b = 24'h5; slow_on = 1'b1;
        push_run(6);
        push_res(1'b1, 24'h4);
        do_en();
        chk("restart_key_valid_cleared", 32'(key_valid), 32'd0);
        chk("restart_key_cleared", 32'(key), 32'd0);
        wait_rdy("tie_done");
        slow_on = 1'b0;
        repeat (5) @(negedge clk);

        // reset mid-RUN; a late pass from a pre-reset dispatch must be dropped
        ok_a = 24'h2; ok_b = 24'hFFFFFF;
        push_run(4);
        do_en();
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_reset_idle_rdy", 32'(rdy), 32'd1);
        chk("post_reset_key_valid", 32'(key_valid), 32'd0);

        // restart from key 0 after reset, core 1 passes key 1
        ok_a = 24'h1;
        push_run(2);
        push_res(1'b1, 24'h1);
        do_en();
        wait_rdy("after_reset_done");
        repeat (5) @(negedge clk);

        chk("dispatch_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("result_queue_drained", 32'(res_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
